// File: rtl/alu_ctrl_pkg.sv
// ALU operation encodings and multiply sequencer state type.
// Shared by the control unit, the alu and the multiply sequencer.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Combinational alu: ADD, SLL, SRL (others yield 0), plus Zero flag.
// Ports: alu_control, src_a, src_b in; alu_result, zero out.
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SLL: alu_result = src_a << shamt;
            ALU_SRL: alu_result = src_a >> shamt;
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier (low word) driving a private alu.
// Ports: clk, rst, start, kill, op_a, op_b in; busy, done, result out.
module alu_mul_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    mul_state_t state, next_state;

    logic [DATA_WIDTH-1:0] acc, mcand, mplier;
    logic [DATA_WIDTH-1:0] src_a, src_b, alu_y;
    logic [3:0]            alu_ctrl;
    logic                  alu_zero;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .alu_control (alu_ctrl),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_result  (alu_y),
        .zero        (alu_zero)
    );

    always_comb begin
        next_state = state;
        alu_ctrl   = ALU_ADD;
        src_a      = '0;
        src_b      = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op_b == '0)
                        next_state = S_DONE;
                    else if (op_b[0])
                        next_state = S_ADD;
                    else
                        next_state = S_SHL;
                end
            end
            S_ADD: begin
                src_a      = acc;
                src_b      = mcand;
                next_state = S_SHL;
            end
            S_SHL: begin
                alu_ctrl   = ALU_SLL;
                src_a      = mcand;
                src_b      = DATA_WIDTH'(1);
                next_state = S_SHR;
            end
            S_SHR: begin
                alu_ctrl = ALU_SRL;
                src_a    = mplier;
                src_b    = DATA_WIDTH'(1);
                // Multiplier exhausted ends the loop; no bit counter.
                if (alu_zero)
                    next_state = S_DONE;
                else if (alu_y[0])
                    next_state = S_ADD;
                else
                    next_state = S_SHL;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // Flush beats everything, including a start in S_IDLE.
        if (kill)
            next_state = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= (next_state == S_DONE);
            if (!kill) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            acc    <= '0;
                            mcand  <= op_a;
                            mplier <= op_b;
                            result <= '0;
                        end
                    end
                    S_ADD:   acc    <= alu_y;
                    S_SHL:   mcand  <= alu_y;
                    S_SHR:   mplier <= alu_y;
                    S_DONE:  result <= acc;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer.
// Checks latency, busy/done timing, results, kill and async reset.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;
    int n;

    alu_mul_sequencer #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op; returns in cycle 1 (one edge after acceptance).
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycle index at which done is seen, counting from cycle 1.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        op_a   = '0;
        op_b   = '0;
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        #2 rst = 1'b0;
        tick();

        // 3 * 5: two set bits, one zero bit below MSB -> 9 cycles
        launch(32'd3, 32'd5);
        chk("a_busy_c1", {31'b0, busy}, 32'd1);
        chk("a_done_c1", {31'b0, done}, 32'd0);
        wait_done(n);
        chk("a_latency", n, 32'd9);
        chk("a_busy_c9", {31'b0, busy}, 32'd1);
        tick();
        chk("a_done_drop", {31'b0, done}, 32'd0);
        chk("a_busy_drop", {31'b0, busy}, 32'd0);
        chk("a_result", result, 32'd15);

        // multiplier zero -> done the next cycle
        launch(32'h1234, 32'd0);
        chk("b_done_c1", {31'b0, done}, 32'd1);
        tick();
        chk("b_result", result, 32'd0);
        chk("b_busy", {31'b0, busy}, 32'd0);

        // all-ones squared -> 97 cycles, low word 1
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("c_latency", n, 32'd97);
        tick();
        chk("c_result", result, 32'h0000_0001);

        // 7 * 6 with a stray start in cycle 3 (ignored)
        launch(32'd7, 32'd6);
        tick();
        tick();
        op_a  = 32'd1;
        op_b  = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 4;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("d_latency", n, 32'd9);
        tick();
        chk("d_result", result, 32'd42);

        // 9 * 9 killed in cycle 4: back to idle, no done
        launch(32'd9, 32'd9);
        tick();
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("e_busy", {31'b0, busy}, 32'd0);
        chk("e_done", {31'b0, done}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (done)
                n = 1;
            tick();
        end
        chk("e_no_done", {31'b0, done}, 32'd0);
        chk("e_result", result, 32'd0);

        // start and kill together in idle: nothing accepted
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        kill  = 1'b1;
        tick();
        start = 1'b0;
        kill  = 1'b0;
        chk("f_busy", {31'b0, busy}, 32'd0);

        // async reset mid-op in cycle 3, then a clean op
        launch(32'd2, 32'd3);
        tick();
        tick();
        chk("g_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("g_busy_rst", {31'b0, busy}, 32'd0);
        chk("g_done_rst", {31'b0, done}, 32'd0);
        chk("g_result_rst", result, 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        launch(32'd3, 32'd5);
        wait_done(n);
        chk("g_latency", n, 32'd9);
        tick();
        chk("g_result", result, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
